// File: rtl/multi_filter_udiv_15ns_9ns_7_seq_pkg.sv
// Shared constants, FSM encodings and result type for the multi_filter
// sequential divider (15-bit dividend / 9-bit divisor -> 7-bit quotient).
package multi_filter_udiv_15ns_9ns_7_seq_pkg;

  localparam int DIN0_WIDTH = 15;
  localparam int DIN1_WIDTH = 9;
  localparam int DOUT_WIDTH = 7;

  // Counter only has to reach DIN0_WIDTH-1.
  localparam int CNT_W = $clog2(DIN0_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [DOUT_WIDTH-1:0] dout;
    logic [DIN1_WIDTH-1:0] rem;
    logic                  sat;
    logic                  dbz;
  } div_result_t;

  // Clamp the full quotient to the output width; MSB of the return is the
  // saturation flag, the rest is the clamped quotient.
  function automatic logic [DOUT_WIDTH:0] saturate_quot(input logic [DIN0_WIDTH-1:0] q);
    logic over;
    over = |q[DIN0_WIDTH-1:DOUT_WIDTH];
    if (over) begin
      return {1'b1, {DOUT_WIDTH{1'b1}}};
    end
    return {1'b0, q[DOUT_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/multi_filter_udiv_15ns_9ns_7_seq_if.sv
// Valid/ready operand and result bundle for the multi_filter divider.
// master = the side feeding operands and taking results; slave = the divider.
interface multi_filter_udiv_15ns_9ns_7_seq_if;
  import multi_filter_udiv_15ns_9ns_7_seq_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;

  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic [DIN1_WIDTH-1:0] rem;
  logic                  sat;
  logic                  dbz;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem, sat, dbz
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem, sat, dbz
  );

endinterface

// File: rtl/multi_filter_udiv_15ns_9ns_7_seq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, compare against the divisor, conditionally subtract.
module multi_filter_udiv_15ns_9ns_7_seq_step
  import multi_filter_udiv_15ns_9ns_7_seq_pkg::*;
(
  input  logic [DIN1_WIDTH-1:0] r,
  input  logic                  din_bit,
  input  logic [DIN1_WIDTH-1:0] divisor,
  output logic [DIN1_WIDTH-1:0] r_next,
  output logic                  q_bit
);

  // One extra bit so the shifted remainder (< 2*divisor) cannot overflow.
  logic [DIN1_WIDTH:0] r_sh;

  // Compare/subtract; the difference always fits DIN1_WIDTH bits because
  // r < divisor on entry, so the subtraction is done modulo 2^DIN1_WIDTH.
  always_comb begin
    r_sh   = {r, din_bit};
    q_bit  = (r_sh >= {1'b0, divisor});
    r_next = r_sh[DIN1_WIDTH-1:0];
    if (q_bit) begin
      r_next = r_sh[DIN1_WIDTH-1:0] - divisor;
    end
  end

endmodule

// File: rtl/multi_filter_udiv_15ns_9ns_7_seq.sv
// Sequential unsigned restoring divider used to renormalise the multi_filter
// accumulator sum by the kernel weight sum. One division in flight; results
// are held in registers until the downstream handshake completes.
module multi_filter_udiv_15ns_9ns_7_seq
  import multi_filter_udiv_15ns_9ns_7_seq_pkg::*;
(
  input  logic                                  ap_clk,
  input  logic                                  ap_rst,
  multi_filter_udiv_15ns_9ns_7_seq_if.slave     bus
);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [DIN0_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIN1_WIDTH-1:0] dsr_q, dsr_d;
  logic [DIN1_WIDTH-1:0] r_q, r_d;
  logic                  zero_q, zero_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  div_result_t           res_q, res_d;

  logic [DIN1_WIDTH-1:0] step_r;
  logic                  step_q;
  logic [DOUT_WIDTH:0]   sat_quot;

  multi_filter_udiv_15ns_9ns_7_seq_step u_step (
    .r       (r_q),
    .din_bit (dvd_q[DIN0_WIDTH-1]),
    .divisor (dsr_q),
    .r_next  (step_r),
    .q_bit   (step_q)
  );

  assign sat_quot = saturate_quot(dvd_q);

  // Next-state logic: accept in IDLE, iterate in CALC, present/hold in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    r_d         = r_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) begin
          dvd_d      = bus.din0;
          dsr_d      = bus.din1;
          r_d        = '0;
          zero_d     = (bus.din1 == '0);
          cnt_d      = CNT_W'(DIN0_WIDTH - 1);
          in_ready_d = 1'b0;
          state_d    = S_CALC;
        end
      end

      S_CALC: begin
        if (zero_q) begin
          // Divide by zero: no iterations, dividend kept intact for rem.
          state_d = S_DONE;
        end else begin
          r_d   = step_r;
          dvd_d = {dvd_q[DIN0_WIDTH-2:0], step_q};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!out_valid_q) begin
          // First DONE cycle: register the final (saturated) result.
          out_valid_d = 1'b1;
          if (zero_q) begin
            res_d.dout = {DOUT_WIDTH{1'b1}};
            res_d.rem  = dvd_q[DIN1_WIDTH-1:0];
            res_d.sat  = 1'b1;
            res_d.dbz  = 1'b1;
          end else begin
            res_d.dout = sat_quot[DOUT_WIDTH-1:0];
            res_d.rem  = r_q;
            res_d.sat  = sat_quot[DOUT_WIDTH];
            res_d.dbz  = 1'b0;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any division and drops a pending result.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      r_q         <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      r_q         <= r_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = res_q.dout;
  assign bus.rem       = res_q.rem;
  assign bus.sat       = res_q.sat;
  assign bus.dbz       = res_q.dbz;

endmodule

// File: tb/tb_multi_filter_udiv_15ns_9ns_7_seq.sv
// Scoreboard bench for the multi_filter sequential divider.
module tb_multi_filter_udiv_15ns_9ns_7_seq;
  import multi_filter_udiv_15ns_9ns_7_seq_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst;

  always #5 ap_clk = ~ap_clk;

  multi_filter_udiv_15ns_9ns_7_seq_if bus ();

  multi_filter_udiv_15ns_9ns_7_seq dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  typedef struct {
    int a;
    int b;
    int dout;
    int rem;
    int sat;
    int dbz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total  = 0;
  int   bad    = 0;
  int   txn    = 0;
  int   pushed = 0;
  bit   done   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   q;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.dout = 127;
      e.rem  = a % 512;
      e.sat  = 1;
      e.dbz  = 1;
    end else begin
      q      = a / b;
      e.rem  = a % b;
      e.sat  = (q > 127) ? 1 : 0;
      e.dout = (q > 127) ? 127 : q;
      e.dbz  = 0;
    end
    return e;
  endfunction

  // Result monitor: every handshake pops the oldest expected result.
  always @(negedge ap_clk) begin
    if (ap_rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        txn++;
        $display("txn %0d: %0d / %0d -> dout=%0d rem=%0d sat=%0d dbz=%0d",
                 txn, mon_e.a, mon_e.b, bus.dout, bus.rem, bus.sat, bus.dbz);
        chk("sb_dout", 32'(bus.dout), mon_e.dout);
        chk("sb_rem",  32'(bus.rem),  mon_e.rem);
        chk("sb_sat",  32'(bus.sat),  mon_e.sat);
        chk("sb_dbz",  32'(bus.dbz),  mon_e.dbz);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int a, input int b, input bit push);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.din0     = 15'(a);
    bus.din1     = 9'(b);
    while (n < 200) begin
      @(negedge ap_clk);
      if (bus.in_ready === 1'b1) break;
      n++;
    end
    if (n >= 200) chk("accept_timeout_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge ap_clk);
    if (push) begin
      sb_q.push_back(model(a, b));
      pushed++;
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges from the accepting edge until out_valid is seen (at a negedge).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge ap_clk);
      if (bus.out_valid === 1'b1) break;
      @(posedge ap_clk);
      lat++;
    end
    if (lat >= 100) chk("valid_timeout_out_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic directed(input string nm, input int a, input int b, input int e_dout,
                          input int e_rem, input int e_sat, input int e_dbz, input int e_lat);
    int lat;
    send(a, b, 1'b1);
    wait_valid(lat);
    chk({nm, "_latency"}, lat, e_lat);
    chk({nm, "_dout"}, 32'(bus.dout), e_dout);
    chk({nm, "_rem"},  32'(bus.rem),  e_rem);
    chk({nm, "_sat"},  32'(bus.sat),  e_sat);
    chk({nm, "_dbz"},  32'(bus.dbz),  e_dbz);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    int n;
    ap_rst        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    // Reset values
    @(negedge ap_clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dout",      32'(bus.dout),      32'd0);
    chk("rst_rem",       32'(bus.rem),       32'd0);
    chk("rst_sat",       32'(bus.sat),       32'd0);
    chk("rst_dbz",       32'(bus.dbz),       32'd0);
    @(posedge ap_clk);
    #1;

    directed("t1", 1000, 9, 111, 1, 0, 0, 16);
    directed("t2", 32767, 1, 127, 0, 1, 0, 16);
    directed("t3", 500, 0, 127, 500, 1, 1, 2);

    // Back-pressure: result held, new operands ignored while in DONE
    bus.out_ready = 1'b0;
    send(255, 2, 1'b1);
    wait_valid(lat);
    chk("t4_latency", lat, 16);
    @(posedge ap_clk);
    #1;
    bus.in_valid = 1'b1;
    bus.din0     = 15'd7;
    bus.din1     = 9'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      chk("t4_hold_dout",      32'(bus.dout),      32'd127);
      chk("t4_hold_rem",       32'(bus.rem),       32'd1);
      chk("t4_hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_in_ready",  32'(bus.in_ready),  32'd0);
      @(posedge ap_clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("t4_idle_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t4_idle_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge ap_clk);
    #1;

    // Reset during CALC, with in_valid asserted alongside the reset
    send(1000, 9, 1'b0);
    repeat (5) @(posedge ap_clk);
    #1;
    ap_rst       = 1'b1;
    bus.in_valid = 1'b1;
    bus.din0     = 15'd100;
    bus.din1     = 9'd3;
    @(posedge ap_clk);
    #1;
    ap_rst       = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge ap_clk);
    chk("t5_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge ap_clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("t5_no_result", 32'(seen), 32'd0);
    @(posedge ap_clk);
    #1;
    directed("t5", 81, 9, 9, 0, 0, 0, 16);

    // Random back-to-back operands with random downstream readiness
    fork
      begin
        int a;
        int b;
        int sel;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge ap_clk);
            #1;
          end
          a   = int'($urandom_range(0, 32767));
          sel = int'($urandom_range(0, 9));
          if (sel == 0)      b = 0;
          else if (sel < 4)  b = int'($urandom_range(1, 15));
          else               b = int'($urandom_range(1, 511));
          send(a, b, 1'b1);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
          @(posedge ap_clk);
          n++;
        end
        chk("t6_drain_pending", 32'(sb_q.size()), 32'd0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge ap_clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (5) @(posedge ap_clk);
    chk("t6_result_count", txn, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
